// File: rtl/fifo_rd_arb_pkg.sv
// Shared types and default sizing for the FIFO read-port arbiter.
package fifo_rd_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SERVE = 1'b1
    } arb_state_e;

    localparam int unsigned DEF_NUM_REQ    = 4;
    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_BURST_LEN  = 4;

    // Requester index width; a single requester still needs one bit.
    function automatic int unsigned id_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin search: first asserted request at or after last+1, wrapping.
module rr_pick #(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned ID_WIDTH = 2
) (
    input  logic [NUM_REQ-1:0]  req,
    input  logic [ID_WIDTH-1:0] last,
    output logic [ID_WIDTH-1:0] winner,
    output logic                any
);

    // Scan farthest offset first so the nearest candidate overwrites the rest.
    always_comb begin
        winner = '0;
        any    = 1'b0;
        for (int unsigned i = NUM_REQ; i >= 1; i--) begin
            if (req[(int'(last) + i) % NUM_REQ]) begin
                winner = ID_WIDTH'((int'(last) + i) % NUM_REQ);
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fifo_rd_arbiter.sv
// Shares one FIFO read port among NUM_REQ requesters with bounded bursts.
module fifo_rd_arbiter
    import fifo_rd_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ    = DEF_NUM_REQ,
    parameter  int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter  int unsigned BURST_LEN  = DEF_BURST_LEN,
    localparam int unsigned ID_WIDTH   = id_width(NUM_REQ)
) (
    input  logic                  rclk,
    input  logic                  rrst,
    input  logic                  rempty,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic [NUM_REQ-1:0]    req,
    output logic                  rinc,
    output logic [NUM_REQ-1:0]    gnt,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ID_WIDTH-1:0]   out_id,
    output logic                  busy
);

    localparam int unsigned CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e          state;
    logic [ID_WIDTH-1:0] cur;
    logic [ID_WIDTH-1:0] last;
    logic [CNT_W-1:0]    burst_cnt;
    logic [ID_WIDTH-1:0] winner;
    logic                any;

    rr_pick #(
        .NUM_REQ  (NUM_REQ),
        .ID_WIDTH (ID_WIDTH)
    ) u_rr_pick (
        .req    (req),
        .last   (last),
        .winner (winner),
        .any    (any)
    );

    // Pop only while the holder still wants data and the FIFO has some.
    always_comb begin
        rinc = (state == SERVE) & req[cur] & ~rempty;
        busy = (state == SERVE);
    end

    // Arbitration FSM, burst counting and registered delivery.
    always_ff @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            state     <= IDLE;
            gnt       <= '0;
            cur       <= '0;
            last      <= ID_WIDTH'(NUM_REQ - 1);
            burst_cnt <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_id    <= '0;
        end else begin
            out_valid <= rinc;
            if (rinc) begin
                out_data <= rdata;
                out_id   <= cur;
            end
            unique case (state)
                IDLE: begin
                    if (any && !rempty) begin
                        state     <= SERVE;
                        gnt       <= NUM_REQ'(1) << winner;
                        cur       <= winner;
                        last      <= winner;
                        burst_cnt <= '0;
                    end
                end
                SERVE: begin
                    if (rinc) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        // Last pop of the burst releases the grant on the same edge.
                        if (burst_cnt == CNT_W'(BURST_LEN - 1)) begin
                            state <= IDLE;
                            gnt   <= '0;
                        end
                    end else begin
                        state <= IDLE;
                        gnt   <= '0;
                    end
                end
                default: begin
                    state <= IDLE;
                    gnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_arbiter.sv
// Randomized + directed bench with a transaction-level model and scoreboard.
module tb_fifo_rd_arbiter;

    localparam int NR    = 4;
    localparam int DW    = 8;
    localparam int BL    = 4;
    localparam int IDW   = 2;
    localparam int DEPTH = 256;

    logic           rclk = 1'b0;
    logic           rrst;
    logic           rempty;
    logic [DW-1:0]  rdata;
    logic [NR-1:0]  req;
    logic           rinc;
    logic [NR-1:0]  gnt;
    logic           out_valid;
    logic [DW-1:0]  out_data;
    logic [IDW-1:0] out_id;
    logic           busy;

    fifo_rd_arbiter #(
        .NUM_REQ    (NR),
        .DATA_WIDTH (DW),
        .BURST_LEN  (BL)
    ) dut (
        .rclk      (rclk),
        .rrst      (rrst),
        .rempty    (rempty),
        .rdata     (rdata),
        .req       (req),
        .rinc      (rinc),
        .gnt       (gnt),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_id    (out_id),
        .busy      (busy)
    );

    always #5 rclk = ~rclk;

    // Simple FIFO model feeding the DUT read port.
    logic [DW-1:0] mem [DEPTH];
    int unsigned   wr_ptr = 0;
    int unsigned   rd_ptr = 0;

    assign rempty = (wr_ptr == rd_ptr);
    assign rdata  = mem[rd_ptr % DEPTH];

    always @(posedge rclk) begin
        if (rinc === 1'b1) rd_ptr <= rd_ptr + 1;
    end

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: who holds the port and what it should receive.
    typedef struct {
        int            id;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   holder  = -1;
    int   last_id = NR - 1;
    int   cnt     = 0;

    always @(posedge rclk or posedge rrst) begin
        if (rrst) begin
            holder  = -1;
            last_id = NR - 1;
            cnt     = 0;
            exp_q.delete();
        end else if (holder < 0) begin
            if (req != '0 && wr_ptr != rd_ptr) begin
                for (int k = 1; k <= NR; k++) begin
                    if (holder < 0 && req[(last_id + k) % NR]) holder = (last_id + k) % NR;
                end
                last_id = holder;
                cnt     = 0;
            end
        end else if (req[holder] && wr_ptr != rd_ptr) begin
            exp_q.push_back('{holder, mem[rd_ptr % DEPTH]});
            cnt++;
            if (cnt == BL) holder = -1;
        end else begin
            holder = -1;
        end
    end

    // Monitor: compare outputs against the model away from the active edge.
    logic        prev_rinc = 1'b0;
    logic [31:0] exp_gnt;
    logic        exp_pop;
    exp_t        got;

    always @(negedge rclk) begin
        if (rrst) begin
            chk("rst_gnt", 32'(gnt), 0);
            chk("rst_rinc", 32'(rinc), 0);
            chk("rst_out_valid", 32'(out_valid), 0);
            chk("rst_out_data", 32'(out_data), 0);
            chk("rst_out_id", 32'(out_id), 0);
            chk("rst_busy", 32'(busy), 0);
            prev_rinc = 1'b0;
        end else begin
            exp_gnt = (holder < 0) ? 32'd0 : (32'd1 << holder);
            exp_pop = (holder >= 0) && req[holder] && !rempty;
            chk("gnt", 32'(gnt), exp_gnt);
            chk("busy", 32'(busy), 32'(holder >= 0));
            chk("rinc", 32'(rinc), 32'(exp_pop));
            chk("rinc_while_empty", 32'(rinc && rempty), 0);
            chk("gnt_onehot0", 32'($onehot0(gnt)), 1);
            chk("out_valid_latency", 32'(out_valid), 32'(prev_rinc));
            if (out_valid === 1'b1) begin
                chk("sb_has_entry", 32'(exp_q.size() != 0), 1);
                if (exp_q.size() != 0) begin
                    got = exp_q.pop_front();
                    chk("out_id", 32'(out_id), 32'(got.id));
                    chk("out_data", 32'(out_data), 32'(got.data));
                end
            end
            prev_rinc = rinc;
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge rclk);
        #1;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            if (wr_ptr - rd_ptr < DEPTH - 8) begin
                mem[wr_ptr % DEPTH] = DW'($urandom);
                wr_ptr++;
            end
        end
    endtask

    task automatic wait_pops(input int target, input int budget);
        int unsigned start;
        start = rd_ptr;
        for (int i = 0; i < budget && int'(rd_ptr - start) < target; i++) cycles(1);
        chk("pops_reached", 32'(int'(rd_ptr - start) >= target), 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;
        rrst = 1'b1;
        req  = '0;
        cycles(3);
        rrst = 1'b0;
        cycles(1);

        // Lone requester with 6 words: burst of 4, idle gap, then 2 more.
        push_words(6);
        req = 4'b0001;
        cycles(12);
        req = '0;
        cycles(2);

        rrst = 1'b1;
        cycles(2);
        rrst = 1'b0;
        cycles(1);

        // All requesting: grant order 0,1,2,3, four words each.
        push_words(16);
        req = 4'b1111;
        cycles(28);
        req = '0;
        cycles(2);

        // Requests while empty must wait; requester 1 wins afterwards.
        req = 4'b0110;
        cycles(5);
        push_words(4);
        cycles(8);
        req = '0;
        cycles(2);

        // Requester 2 withdraws after two pops.
        push_words(8);
        req = 4'b0100;
        wait_pops(2, 20);
        req = '0;
        cycles(3);

        // Reset during the third pop of a burst, then resume.
        req = 4'b0001;
        wait_pops(2, 20);
        rrst = 1'b1;
        cycles(2);
        rrst = 1'b0;
        cycles(12);
        req = '0;
        cycles(3);

        // Random traffic with occasional resets.
        for (int c = 0; c < 400; c++) begin
            req = NR'($urandom);
            if ($urandom_range(0, 3) == 0) push_words(int'($urandom_range(1, 4)));
            if ($urandom_range(0, 99) == 0) begin
                rrst = 1'b1;
                cycles(1);
                rrst = 1'b0;
            end
            cycles(1);
        end

        req = '0;
        cycles(4);
        chk("sb_drained", 32'(exp_q.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fifo_rd_arbiter.md
FIFO_RD_ARBITER -- requirements
Module: fifo_rd_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4: number of read requesters sharing the FIFO read port.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 8: FIFO word width.
REQ-003 The block SHALL have parameter BURST_LEN, default 4: maximum pops per grant (range 1..16).
REQ-004 The block SHALL have derived constant ID_WIDTH = max(1, clog2(NUM_REQ)).
REQ-005 The block SHALL have port rclk, input, 1: the single clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rrst, input, 1: reset, asynchronous and active-high.
REQ-007 The block SHALL have port rempty, input, 1: FIFO read-side empty flag.
REQ-008 The block SHALL have port rdata, input, DATA_WIDTH: FIFO word at the current read address, valid whenever rempty is 0.
REQ-009 The block SHALL have port req, input, NUM_REQ: level request per requester.
REQ-010 The block SHALL have port rinc, output, 1: FIFO pop strobe.
REQ-011 The block SHALL have port gnt, output, NUM_REQ: registered one-hot grant; all zero when idle.
REQ-012 The block SHALL have port out_valid, output, 1: one-cycle delivery strobe.
REQ-013 The block SHALL have port out_data, output, DATA_WIDTH: delivered word.
REQ-014 The block SHALL have port out_id, output, ID_WIDTH: index of the requester receiving out_data.
REQ-015 The block SHALL have port busy, output, 1: high while a grant is held.

Function
REQ-016 The block SHALL implement FSM states IDLE and SERVE; busy = (state == SERVE).
REQ-017 In IDLE with (|req) and !rempty, the block SHALL pick a winner round-robin, searching from index (last+1) mod NUM_REQ upward and wrapping.
REQ-018 On that edge the block SHALL enter SERVE, set gnt to one-hot(winner), set last = winner, and clear burst_cnt to 0.
REQ-019 In IDLE with !(|req) or rempty, the block SHALL stay in IDLE; gnt SHALL be 0 and rinc SHALL be 0.
REQ-020 rinc SHALL be combinational: rinc = (state == SERVE) & req[cur] & !rempty; rinc SHALL never be 1 while rempty is 1.
REQ-021 On each edge with rinc = 1, the block SHALL register out_data <= rdata, out_id <= cur and out_valid <= 1; otherwise out_valid <= 0. Delivery latency SHALL be one cycle after the pop.
REQ-022 On each pop, burst_cnt SHALL increment; the pop that makes burst_cnt reach BURST_LEN SHALL return the FSM to IDLE with gnt cleared on the same edge.
REQ-023 In SERVE with no pop (req[cur] = 0 or rempty = 1), the block SHALL return to IDLE and clear gnt on that edge.
REQ-024 Requests arriving from other requesters during SERVE SHALL NOT preempt the grant; they SHALL be arbitrated in the next IDLE cycle.
REQ-025 A minimum of one IDLE cycle SHALL separate consecutive grants, including back-to-back grants to the same requester.
REQ-026 When only one requester requests, the block SHALL re-grant that requester after the IDLE cycle (no starvation of a lone requester).

Reset
REQ-027 While rrst = 1, the block SHALL force: state = IDLE, gnt = 0, burst_cnt = 0, last = NUM_REQ-1 (so requester 0 has first priority), out_valid = 0, out_data = 0, out_id = 0, rinc = 0.
REQ-028 Reset asserted mid-burst SHALL abort the burst immediately, with no further rinc; words already popped SHALL NOT be replayed.

Structure
REQ-029 A shared package fifo_rd_arb_pkg SHALL hold the state type (IDLE, SERVE) and the default parameter constants.
REQ-030 The block SHALL use one combinational sub-module rr_pick (inputs: req vector, last index; outputs: winner index, any) for the round-robin search.

Verification
REQ-031 Scenario: FIFO holds 6 words, req = 4'b0001 steady -> pops 1-4 back-to-back, then one IDLE cycle, then pops 5-6 with out_id = 0; grant ends when rempty rises.
REQ-032 Scenario: req = 4'b1111, FIFO holds 16 words, BURST_LEN = 4 -> grant order 0, 1, 2, 3; each grant delivers 4 words in FIFO order, with the out_id sequence matching.
REQ-033 Scenario: rempty = 1 and req = 4'b0110 -> gnt stays 0 and rinc stays 0; after the FIFO is written, requester 1 is granted first.
REQ-034 Scenario: requester 2 drops req after 2 pops -> next edge IDLE, out_valid for exactly 2 words with out_id = 2, burst_cnt reset on the next grant.
REQ-035 Scenario: rrst pulsed during the 3rd pop of a burst -> rinc = 0, gnt = 0, out_valid = 0 within the reset; after release, requester 0 is granted first if requesting.
REQ-036 Assertions: rinc implies !rempty; gnt is one-hot or zero; out_valid occurs exactly one cycle after each rinc.
